if_fetch_queue: RTL

//  Instruction-fetch front end of the pipelined RV32IM core: generates sequential PCs,

---
 rtl/if_fetch_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, 1-cycle imem requests,
// a small return FIFO and a valid/ready hand-off of {pc, inst} to decode.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        halted
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   tag_pc_reg;
  logic [CW-1:0] count_reg;
  logic          inflight_reg;
  logic          halt_latched_reg;
  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [CW:0]   credit_limit;

  assign id_valid  = !rst && (count_reg != '0);
  assign pop       = id_valid && id_ready;
  // A returning word always lands in the FIFO (redirect aside), so inflight
  // counts against capacity; a pop this cycle frees a slot before it lands,
  // which is what keeps the stream at one instruction per cycle.
  assign occupancy    = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign credit_limit = DEPTH_C + {{CW{1'b0}}, pop};
  assign issue = !rst && !halt_latched_reg && !redirect_valid && (occupancy < credit_limit);
  assign push  = inflight_reg && !redirect_valid;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_reg & 32'hFFFF_FFFC;

  assign id_pc   = id_valid ? pc_mem[head_reg]   : 32'h0000_0000;
  assign id_inst = id_valid ? inst_mem[head_reg] : NOP_INST;
  assign halted  = !rst && halt_latched_reg && (count_reg == '0) && !inflight_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg     <= RESET_PC;
      tag_pc_reg       <= 32'h0000_0000;
      count_reg        <= '0;
      inflight_reg     <= 1'b0;
      halt_latched_reg <= 1'b0;
      head_reg         <= '0;
      tail_reg         <= '0;
    end else begin
      if (issue) begin
        fetch_pc_reg <= imem_addr + 32'd4;
        tag_pc_reg   <= imem_addr;
      end else if (redirect_valid) begin
        fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
      end
      // The memory answers exactly one cycle later, so inflight tracks issue;
      // a redirect blocks issue, leaving nothing in flight behind it.
      inflight_reg     <= issue;
      halt_latched_reg <= halt_latched_reg | halt_req;

      if (redirect_valid) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + AW'(1);
        if (pop)  head_reg <= head_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Storage needs no reset: count_reg alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]   <= tag_pc_reg;
      inst_mem[tail_reg] <= imem_rdata;
    end
  end

endmodule
